tlb_maint_ctrl: RTL and testbench
=================================

Name: tlb_maint_ctrl

Overview:
Sequences TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) when they reach the WB stage. While an operation is in progress it stalls the WB register, drives the TLB search, read, write and invalidate ports, and pulses the CSR update strobes. On completion it issues a refetch of pc+4 so that younger instructions see the new translation state. It sits between the WB pipeline register, the CSR file and the TLB array.

Parameters:
TLBNUM, 16, number of TLB entries (power of 2)
IDX_W, 4, log2(TLBNUM)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wb_valid  in  1  WB holds a live, non-cancelled instruction
wb_ex  in  1  WB instruction raised an exception
wb_is_ertn  in  1  WB instruction is ERTN
wb_pc  in  32  WB instruction PC
wb_inst_tlbsrch  in  1  TLBSRCH in WB
wb_inst_tlbrd  in  1  TLBRD in WB
wb_tlb_wr_en  in  1  TLBWR in WB
wb_tlb_fill_en  in  1  TLBFILL in WB
wb_invtlb_valid  in  1  INVTLB in WB
wb_invtlb_op  in  5  INVTLB op
wb_invtlb_asid  in  10  INVTLB asid operand
wb_invtlb_va  in  19  INVTLB va[31:13]
csr_tlbidx_index  in  IDX_W  TLBIDX.index
csr_asid  in  10  ASID.asid
csr_tlbehi_vppn  in  19  TLBEHI.vppn
tlb_s_vppn  out  19  search vppn
tlb_s_asid  out  10  search asid
tlb_s_found  in  1  search hit (combinational)
tlb_s_index  in  IDX_W  hit index
tlb_r_index  out  IDX_W  read index (read data is combinational)
tlb_r_e  in  1  entry E
tlb_r_g  in  1  entry G
tlb_r_asid  in  10  entry ASID
tlb_r_vppn  in  19  entry VPPN
tlb_we  out  1  write the entry from CSRs
tlb_w_index  out  IDX_W  write index
tlb_inv_we  out  1  clear E of one entry
tlb_inv_index  out  IDX_W  entry to clear
csr_tlbsrch_we  out  1  commit search result
csr_tlbsrch_found  out  1  search hit
csr_tlbsrch_index  out  IDX_W  search index
csr_tlbrd_we  out  1  load TLBEHI/ELO/IDX/ASID from the read port
wb_stall  out  1  hold the WB register
refetch_valid  out  1  flush younger instructions and refetch
refetch_pc  out  32  refetch target

Behaviour:
- Reset: asynchronous. On rst, state returns to IDLE, all counters and latches clear to 0, and every output is 0.
- States: IDLE, SRCH, RD, WR, INV, DONE.
- start = wb_valid & !wb_ex & !wb_is_ertn & (any op flag). It is evaluated only in IDLE.
- On start:
  - Latch pc, op, asid, va, csr_asid and csr_tlbehi_vppn.
  - Select the next state by priority: INVTLB > TLBFILL > TLBWR > TLBSRCH > TLBRD.
  - wb_stall = start in IDLE (Mealy output). It is 1 in SRCH, RD, WR and INV, and 0 in DONE.
- SRCH (1 cycle): tlb_s_vppn/asid come from the latches. csr_tlbsrch_we=1 with found/index taken from the TLB. Next state DONE.
- RD (1 cycle): tlb_r_index=csr_tlbidx_index, csr_tlbrd_we=1. Next state DONE.
- WR (1 cycle): tlb_we=1.
  - TLBWR: tlb_w_index=csr_tlbidx_index.
  - TLBFILL: tlb_w_index=fill_ctr, sampled at start.
  - Next state DONE.
- fill_ctr: IDX_W-bit free-running counter, +1 every cycle, wraps TLBNUM-1 to 0.
- INV: walks index cnt from 0 to TLBNUM-1, one entry per cycle, with tlb_r_index=cnt.
  - match = tlb_r_e & cond(op). The conditions are:
    - op 0/1: all entries.
    - op 2: G=1.
    - op 3: G=0.
    - op 4: G=0 & asid==latched asid.
    - op 5: op 4 condition & vppn==latched va.
    - op 6: (G=1 | asid match) & vppn match.
  - tlb_inv_we=match, tlb_inv_index=cnt.
  - Leave INV when cnt==TLBNUM-1 (inclusive), then reset cnt to 0. Total INV time is TLBNUM cycles.
  - op>6: no walk and no writes; IDLE goes straight to DONE.
- DONE (1 cycle): refetch_valid=1, refetch_pc=latched pc+4 (mod 2^32). Next state IDLE.
- Back-to-back: a new start is accepted in IDLE the cycle after DONE.
- Once accepted, an operation always completes; wb_ex, wb_is_ertn and wb_valid are ignored outside IDLE.
- Only one strobe among tlb_we, tlb_inv_we, csr_tlbsrch_we and csr_tlbrd_we is active in any cycle.

Decomposition:
- Shared package holds:
  - state encoding (3-bit enum: IDLE, SRCH, RD, WR, INV, DONE);
  - INVTLB op codes 0–6;
  - default TLBNUM and IDX_W.
- One natural sub-module: tlb_inv_match, a combinational match condition over (op, e, g, asid, vppn, latched asid, latched va).

Test Plan:
- TLBSRCH with wb_pc=0x1c000100 and TLB hit at index 5 -> one cycle of csr_tlbsrch_we with found=1 and index=5; the next cycle refetch_valid=1 and refetch_pc=0x1c000104.
- TLBFILL with fill_ctr=9 at start -> tlb_we=1 and tlb_w_index=9 for exactly one cycle; wb_stall is high for 2 cycles in total.
- INVTLB op5, asid=0x3, va=0x12345, with entries 2 (G=0, asid 3, vppn match) and 7 (G=1, same vppn) valid -> tlb_inv_we pulses only at index 2; refetch comes 17 cycles after start.
- INVTLB op 7 -> no tlb_inv_we; DONE follows on the next cycle with a refetch.
- TLBWR asserted together with wb_ex=1 -> not accepted: no stall, no strobes.
- rst asserted at walk index 6 -> all outputs drop to 0 asynchronously; after release, state is IDLE and the next INVTLB walk starts from index 0.

Source files
------------

// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared types and constants for the TLB maintenance sequencer.
package tlb_maint_ctrl_pkg;

    localparam int unsigned TLBNUM_DEF = 16;
    localparam int unsigned IDX_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SRCH = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_INV  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // INVTLB op codes; anything above INV_GA_VA is a no-op walk.
    localparam logic [4:0] INV_ALL0       = 5'd0;
    localparam logic [4:0] INV_ALL1       = 5'd1;
    localparam logic [4:0] INV_G1         = 5'd2;
    localparam logic [4:0] INV_G0         = 5'd3;
    localparam logic [4:0] INV_G0_ASID    = 5'd4;
    localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GA_VA      = 5'd6;

endpackage

// File: rtl/tlb_maint_ctrl_inv_match.sv
// Combinational INVTLB match condition for the entry currently being walked.
module tlb_inv_match
    import tlb_maint_ctrl_pkg::*;
(
    input  logic [4:0]  op,
    input  logic        e,
    input  logic        g,
    input  logic [9:0]  asid,
    input  logic [18:0] vppn,
    input  logic [9:0]  l_asid,
    input  logic [18:0] l_va,
    output logic        match_c
);

    logic asid_eq;
    logic va_eq;
    logic cond;

    // Evaluate the op-specific condition; only valid entries can match.
    always_comb begin
        asid_eq = (asid == l_asid);
        va_eq   = (vppn == l_va);
        cond    = 1'b0;
        case (op)
            INV_ALL0, INV_ALL1: cond = 1'b1;
            INV_G1:             cond = g;
            INV_G0:             cond = ~g;
            INV_G0_ASID:        cond = ~g & asid_eq;
            INV_G0_ASID_VA:     cond = ~g & asid_eq & va_eq;
            INV_GA_VA:          cond = (g | asid_eq) & va_eq;
            default:            cond = 1'b0;
        endcase
        match_c = e & cond;
    end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// Sequences TLB maintenance instructions held in WB and refetches pc+4 afterwards.
module tlb_maint_ctrl
    import tlb_maint_ctrl_pkg::*;
#(
    parameter int unsigned TLBNUM = TLBNUM_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic             wb_ex,
    input  logic             wb_is_ertn,
    input  logic [31:0]      wb_pc,
    input  logic             wb_inst_tlbsrch,
    input  logic             wb_inst_tlbrd,
    input  logic             wb_tlb_wr_en,
    input  logic             wb_tlb_fill_en,
    input  logic             wb_invtlb_valid,
    input  logic [4:0]       wb_invtlb_op,
    input  logic [9:0]       wb_invtlb_asid,
    input  logic [18:0]      wb_invtlb_va,
    input  logic [IDX_W-1:0] csr_tlbidx_index,
    input  logic [9:0]       csr_asid,
    input  logic [18:0]      csr_tlbehi_vppn,
    output logic [18:0]      tlb_s_vppn,
    output logic [9:0]       tlb_s_asid,
    input  logic             tlb_s_found,
    input  logic [IDX_W-1:0] tlb_s_index,
    output logic [IDX_W-1:0] tlb_r_index,
    input  logic             tlb_r_e,
    input  logic             tlb_r_g,
    input  logic [9:0]       tlb_r_asid,
    input  logic [18:0]      tlb_r_vppn,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_w_index,
    output logic             tlb_inv_we,
    output logic [IDX_W-1:0] tlb_inv_index,
    output logic             csr_tlbsrch_we,
    output logic             csr_tlbsrch_found,
    output logic [IDX_W-1:0] csr_tlbsrch_index,
    output logic             csr_tlbrd_we,
    output logic             wb_stall,
    output logic             refetch_valid,
    output logic [31:0]      refetch_pc
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

    state_e           state_q;
    state_e           state_d;
    logic [31:0]      pc_q;
    logic [4:0]       op_q;
    logic [9:0]       asid_q;
    logic [18:0]      va_q;
    logic [9:0]       s_asid_q;
    logic [18:0]      s_vppn_q;
    logic             is_fill_q;
    logic [IDX_W-1:0] fill_idx_q;
    logic [IDX_W-1:0] fill_ctr_q;
    logic [IDX_W-1:0] cnt_q;
    logic             any_op_c;
    logic             start_c;
    logic             match_c;

    // Per-entry invalidate condition for the entry at the walk index.
    tlb_inv_match u_match (
        .op      (op_q),
        .e       (tlb_r_e),
        .g       (tlb_r_g),
        .asid    (tlb_r_asid),
        .vppn    (tlb_r_vppn),
        .l_asid  (asid_q),
        .l_va    (va_q),
        .match_c (match_c)
    );

    // Accept a new maintenance op only from IDLE and never while in reset.
    always_comb begin
        any_op_c = wb_inst_tlbsrch | wb_inst_tlbrd | wb_tlb_wr_en | wb_tlb_fill_en | wb_invtlb_valid;
        start_c  = ~rst & (state_q == ST_IDLE) & wb_valid & ~wb_ex & ~wb_is_ertn & any_op_c;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latches captured on start so WB changes cannot disturb an op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            op_q       <= '0;
            asid_q     <= '0;
            va_q       <= '0;
            s_asid_q   <= '0;
            s_vppn_q   <= '0;
            is_fill_q  <= 1'b0;
            fill_idx_q <= '0;
        end else if (start_c) begin
            pc_q       <= wb_pc;
            op_q       <= wb_invtlb_op;
            asid_q     <= wb_invtlb_asid;
            va_q       <= wb_invtlb_va;
            s_asid_q   <= csr_asid;
            s_vppn_q   <= csr_tlbehi_vppn;
            is_fill_q  <= wb_tlb_fill_en & ~wb_invtlb_valid;
            fill_idx_q <= fill_ctr_q;
        end
    end

    // Free-running TLBFILL victim counter and the INVTLB walk index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_ctr_q <= '0;
            cnt_q      <= '0;
        end else begin
            fill_ctr_q <= fill_ctr_q + IDX_W'(1);
            if (state_q == ST_INV) begin
                cnt_q <= (cnt_q == LAST_IDX) ? '0 : cnt_q + IDX_W'(1);
            end
        end
    end

    assign tlb_s_vppn = s_vppn_q;
    assign tlb_s_asid = s_asid_q;

    // Next-state and per-state port drive; at most one strobe per state.
    always_comb begin
        state_d           = state_q;
        wb_stall          = 1'b0;
        tlb_r_index       = '0;
        tlb_we            = 1'b0;
        tlb_w_index       = '0;
        tlb_inv_we        = 1'b0;
        tlb_inv_index     = '0;
        csr_tlbsrch_we    = 1'b0;
        csr_tlbsrch_found = 1'b0;
        csr_tlbsrch_index = '0;
        csr_tlbrd_we      = 1'b0;
        refetch_valid     = 1'b0;
        refetch_pc        = '0;
        case (state_q)
            ST_IDLE: begin
                wb_stall = start_c;
                if (start_c) begin
                    if (wb_invtlb_valid) begin
                        state_d = (wb_invtlb_op <= INV_GA_VA) ? ST_INV : ST_DONE;
                    end else if (wb_tlb_fill_en || wb_tlb_wr_en) begin
                        state_d = ST_WR;
                    end else if (wb_inst_tlbsrch) begin
                        state_d = ST_SRCH;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_SRCH: begin
                wb_stall          = 1'b1;
                csr_tlbsrch_we    = 1'b1;
                csr_tlbsrch_found = tlb_s_found;
                csr_tlbsrch_index = tlb_s_index;
                state_d           = ST_DONE;
            end
            ST_RD: begin
                wb_stall     = 1'b1;
                tlb_r_index  = csr_tlbidx_index;
                csr_tlbrd_we = 1'b1;
                state_d      = ST_DONE;
            end
            ST_WR: begin
                wb_stall    = 1'b1;
                tlb_we      = 1'b1;
                tlb_w_index = is_fill_q ? fill_idx_q : csr_tlbidx_index;
                state_d     = ST_DONE;
            end
            ST_INV: begin
                wb_stall      = 1'b1;
                tlb_r_index   = cnt_q;
                tlb_inv_we    = match_c;
                tlb_inv_index = cnt_q;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                refetch_valid = 1'b1;
                refetch_pc    = pc_q + 32'd4;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Self-checking bench for tlb_maint_ctrl: directed table, reset corner case, random ops.
module tb_tlb_maint_ctrl;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_valid, wb_ex, wb_is_ertn;
    logic [31:0]      wb_pc;
    logic             wb_inst_tlbsrch, wb_inst_tlbrd, wb_tlb_wr_en, wb_tlb_fill_en, wb_invtlb_valid;
    logic [4:0]       wb_invtlb_op;
    logic [9:0]       wb_invtlb_asid;
    logic [18:0]      wb_invtlb_va;
    logic [IDX_W-1:0] csr_tlbidx_index;
    logic [9:0]       csr_asid;
    logic [18:0]      csr_tlbehi_vppn;
    logic [18:0]      tlb_s_vppn;
    logic [9:0]       tlb_s_asid;
    logic             tlb_s_found;
    logic [IDX_W-1:0] tlb_s_index;
    logic [IDX_W-1:0] tlb_r_index;
    logic             tlb_r_e, tlb_r_g;
    logic [9:0]       tlb_r_asid;
    logic [18:0]      tlb_r_vppn;
    logic             tlb_we;
    logic [IDX_W-1:0] tlb_w_index;
    logic             tlb_inv_we;
    logic [IDX_W-1:0] tlb_inv_index;
    logic             csr_tlbsrch_we, csr_tlbsrch_found;
    logic [IDX_W-1:0] csr_tlbsrch_index;
    logic             csr_tlbrd_we;
    logic             wb_stall;
    logic             refetch_valid;
    logic [31:0]      refetch_pc;

    tlb_maint_ctrl dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_is_ertn(wb_is_ertn), .wb_pc(wb_pc),
        .wb_inst_tlbsrch(wb_inst_tlbsrch), .wb_inst_tlbrd(wb_inst_tlbrd),
        .wb_tlb_wr_en(wb_tlb_wr_en), .wb_tlb_fill_en(wb_tlb_fill_en),
        .wb_invtlb_valid(wb_invtlb_valid), .wb_invtlb_op(wb_invtlb_op),
        .wb_invtlb_asid(wb_invtlb_asid), .wb_invtlb_va(wb_invtlb_va),
        .csr_tlbidx_index(csr_tlbidx_index), .csr_asid(csr_asid), .csr_tlbehi_vppn(csr_tlbehi_vppn),
        .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
        .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
        .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_g(tlb_r_g),
        .tlb_r_asid(tlb_r_asid), .tlb_r_vppn(tlb_r_vppn),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
        .tlb_inv_we(tlb_inv_we), .tlb_inv_index(tlb_inv_index),
        .csr_tlbsrch_we(csr_tlbsrch_we), .csr_tlbsrch_found(csr_tlbsrch_found),
        .csr_tlbsrch_index(csr_tlbsrch_index), .csr_tlbrd_we(csr_tlbrd_we),
        .wb_stall(wb_stall), .refetch_valid(refetch_valid), .refetch_pc(refetch_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, ex, ertn, srch, rd, wr, fill, inv;
        logic [4:0]  op;
        logic [9:0]  asid;
        logic [18:0] va;
        logic [31:0] pc;
        logic [3:0]  idx;
        logic [9:0]  ca;
        logic [18:0] cv;
    } op_in_t;

    typedef struct {
        logic stall, we, inv_we, srch_we, rd_we, rf, s_found;
        logic [3:0]  w_idx, inv_idx, s_idx, r_idx;
        logic [31:0] rf_pc;
    } obs_t;

    typedef struct {
        int stall_n, strobe_n, rf_at;
        logic [3:0]  first_idx;
        logic [31:0] rf_pc;
    } summ_t;

    typedef struct {
        op_in_t      in;
        int          align;
        int          x_stall, x_strobes, x_rf_at;
        logic [3:0]  x_idx;
        logic [31:0] x_rf_pc;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int edges;
    obs_t exp_q[$];
    vec_t tbl[$];

    // Behavioural TLB contents seen by the DUT.
    logic        m_e    [TLBNUM];
    logic        m_g    [TLBNUM];
    logic [9:0]  m_asid [TLBNUM];
    logic [18:0] m_vppn [TLBNUM];

    // Clock edges since reset release; equals the fill victim counter.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    function automatic logic [4:0] tlb_lookup(logic [18:0] v, logic [9:0] a);
        for (int i = 0; i < TLBNUM; i++)
            if (m_e[i] && m_vppn[i] == v && (m_g[i] || m_asid[i] == a)) return {1'b1, 4'(i)};
        return 5'd0;
    endfunction

    always_comb begin
        tlb_r_e    = m_e[tlb_r_index];
        tlb_r_g    = m_g[tlb_r_index];
        tlb_r_asid = m_asid[tlb_r_index];
        tlb_r_vppn = m_vppn[tlb_r_index];
        {tlb_s_found, tlb_s_index} = tlb_lookup(tlb_s_vppn, tlb_s_asid);
    end

    function automatic bit inv_hit(int op, int i, logic [9:0] la, logic [18:0] lv);
        bit same_asid = (m_asid[i] == la);
        bit same_va   = (m_vppn[i] == lv);
        if (!m_e[i]) return 1'b0;
        case (op)
            0, 1:    return 1'b1;
            2:       return m_g[i];
            3:       return !m_g[i];
            4:       return !m_g[i] && same_asid;
            5:       return !m_g[i] && same_asid && same_va;
            6:       return (m_g[i] || same_asid) && same_va;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit accepted(op_in_t o);
        return o.v && !o.ex && !o.ertn && (o.srch || o.rd || o.wr || o.fill || o.inv);
    endfunction

    // Expected per-cycle outputs, starting with the cycle the op is presented.
    task automatic build_trace(input op_in_t o, input int fill_now);
        obs_t z;
        obs_t e;
        logic [4:0] s;
        z = '{default: '0};
        exp_q.delete();
        if (!accepted(o)) begin
            exp_q.push_back(z);
            exp_q.push_back(z);
            return;
        end
        e = z; e.stall = 1'b1; exp_q.push_back(e);
        if (o.inv) begin
            if (o.op <= 5'd6) begin
                for (int i = 0; i < TLBNUM; i++) begin
                    e = z; e.stall = 1'b1;
                    e.inv_we = inv_hit(int'(o.op), i, o.asid, o.va);
                    e.inv_idx = 4'(i);
                    exp_q.push_back(e);
                end
            end
        end else if (o.fill) begin
            e = z; e.stall = 1'b1; e.we = 1'b1; e.w_idx = 4'(fill_now % TLBNUM); exp_q.push_back(e);
        end else if (o.wr) begin
            e = z; e.stall = 1'b1; e.we = 1'b1; e.w_idx = o.idx; exp_q.push_back(e);
        end else if (o.srch) begin
            s = tlb_lookup(o.cv, o.ca);
            e = z; e.stall = 1'b1; e.srch_we = 1'b1; e.s_found = s[4]; e.s_idx = s[3:0]; exp_q.push_back(e);
        end else begin
            e = z; e.stall = 1'b1; e.rd_we = 1'b1; e.r_idx = o.idx; exp_q.push_back(e);
        end
        e = z; e.rf = 1'b1; e.rf_pc = o.pc + 32'd4; exp_q.push_back(e);
    endtask

    function automatic bit obs_eq(obs_t e, obs_t a);
        if ({e.stall, e.we, e.inv_we, e.srch_we, e.rd_we, e.rf} !== {a.stall, a.we, a.inv_we, a.srch_we, a.rd_we, a.rf}) return 1'b0;
        if (e.we && a.w_idx !== e.w_idx) return 1'b0;
        if (e.inv_we && a.inv_idx !== e.inv_idx) return 1'b0;
        if (e.srch_we && (a.s_found !== e.s_found || a.s_idx !== e.s_idx)) return 1'b0;
        if (e.rd_we && a.r_idx !== e.r_idx) return 1'b0;
        if (e.rf && a.rf_pc !== e.rf_pc) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string obs_str(obs_t o);
        return $sformatf("st=%b we=%b/%0d inv=%b/%0d srch=%b/%b/%0d rd=%b/%0d rf=%b/%h",
                         o.stall, o.we, o.w_idx, o.inv_we, o.inv_idx, o.srch_we, o.s_found, o.s_idx,
                         o.rd_we, o.r_idx, o.rf, o.rf_pc);
    endfunction

    task automatic chk_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic chk_all_zero(input string name);
        logic [83:0] ov;
        ov = {wb_stall, tlb_we, tlb_inv_we, csr_tlbsrch_we, csr_tlbrd_we, refetch_valid, csr_tlbsrch_found,
              refetch_pc, tlb_w_index, tlb_inv_index, tlb_r_index, csr_tlbsrch_index, tlb_s_vppn, tlb_s_asid};
        n_tests++;
        if (ov !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs %h, expected all zero", name, ov);
        end
    endtask

    task automatic drive_op(input op_in_t o);
        wb_valid = o.v; wb_ex = o.ex; wb_is_ertn = o.ertn; wb_pc = o.pc;
        wb_inst_tlbsrch = o.srch; wb_inst_tlbrd = o.rd; wb_tlb_wr_en = o.wr;
        wb_tlb_fill_en = o.fill; wb_invtlb_valid = o.inv; wb_invtlb_op = o.op;
        wb_invtlb_asid = o.asid; wb_invtlb_va = o.va;
        csr_tlbidx_index = o.idx; csr_asid = o.ca; csr_tlbehi_vppn = o.cv;
    endtask

    task automatic drive_idle(input logic [3:0] idx);
        wb_valid = 1'b0; wb_ex = 1'b0; wb_is_ertn = 1'b0; wb_pc = '0;
        wb_inst_tlbsrch = 1'b0; wb_inst_tlbrd = 1'b0; wb_tlb_wr_en = 1'b0;
        wb_tlb_fill_en = 1'b0; wb_invtlb_valid = 1'b0; wb_invtlb_op = '0;
        wb_invtlb_asid = '0; wb_invtlb_va = '0;
        csr_tlbidx_index = idx; csr_asid = '0; csr_tlbehi_vppn = '0;
    endtask

    // Garbage on WB and latched-at-start CSRs while an op is in flight.
    task automatic drive_junk(input logic [3:0] idx);
        wb_valid = 1'($urandom); wb_ex = 1'($urandom); wb_is_ertn = 1'($urandom); wb_pc = $urandom;
        wb_inst_tlbsrch = 1'($urandom); wb_inst_tlbrd = 1'($urandom); wb_tlb_wr_en = 1'($urandom);
        wb_tlb_fill_en = 1'($urandom); wb_invtlb_valid = 1'($urandom); wb_invtlb_op = 5'($urandom);
        wb_invtlb_asid = 10'($urandom); wb_invtlb_va = 19'($urandom);
        csr_tlbidx_index = idx; csr_asid = 10'($urandom); csr_tlbehi_vppn = 19'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the op's last cycle.
    task automatic run_op(input op_in_t o, input string tag, output summ_t s);
        obs_t a;
        bit   acc;
        acc = accepted(o);
        build_trace(o, edges);
        s = '{stall_n: 0, strobe_n: 0, rf_at: -1, first_idx: 4'd0, rf_pc: 32'd0};
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 0) drive_op(o);
            else if (acc) drive_junk(o.idx);
            else drive_idle(o.idx);
            @(negedge clk);
            a.stall = wb_stall; a.we = tlb_we; a.w_idx = tlb_w_index;
            a.inv_we = tlb_inv_we; a.inv_idx = tlb_inv_index;
            a.srch_we = csr_tlbsrch_we; a.s_found = csr_tlbsrch_found; a.s_idx = csr_tlbsrch_index;
            a.rd_we = csr_tlbrd_we; a.r_idx = tlb_r_index;
            a.rf = refetch_valid; a.rf_pc = refetch_pc;
            n_tests++;
            if (!obs_eq(exp_q[k], a)) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got [%s] expected [%s]", tag, k, obs_str(a), obs_str(exp_q[k]));
            end
            s.stall_n += int'(a.stall);
            if (a.we || a.inv_we || a.srch_we || a.rd_we) begin
                if (s.strobe_n == 0)
                    s.first_idx = a.we ? a.w_idx : a.inv_we ? a.inv_idx : a.srch_we ? a.s_idx : a.r_idx;
                s.strobe_n++;
            end
            if (a.rf && s.rf_at < 0) begin
                s.rf_at = k;
                s.rf_pc = a.rf_pc;
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic op_in_t mk(logic v, logic ex, logic ertn, logic srch, logic rd, logic wr, logic fill,
                                  logic inv, logic [4:0] op, logic [9:0] asid, logic [18:0] va,
                                  logic [31:0] pc, logic [3:0] idx, logic [9:0] ca, logic [18:0] cv);
        op_in_t o;
        o.v = v; o.ex = ex; o.ertn = ertn; o.srch = srch; o.rd = rd; o.wr = wr; o.fill = fill; o.inv = inv;
        o.op = op; o.asid = asid; o.va = va; o.pc = pc; o.idx = idx; o.ca = ca; o.cv = cv;
        return o;
    endfunction

    task automatic add(input op_in_t o, input int align, input int st, input int sn, input int rfa,
                       input logic [3:0] idx, input logic [31:0] rfpc);
        vec_t v;
        v.in = o; v.align = align; v.x_stall = st; v.x_strobes = sn; v.x_rf_at = rfa;
        v.x_idx = idx; v.x_rf_pc = rfpc;
        tbl.push_back(v);
    endtask

    task automatic preset_tlb();
        for (int i = 0; i < TLBNUM; i++) begin
            m_e[i] = 1'b0; m_g[i] = 1'b0; m_asid[i] = 10'h3ff; m_vppn[i] = 19'h7ffff;
        end
        m_e[2]  = 1'b1; m_g[2]  = 1'b0; m_asid[2]  = 10'h003; m_vppn[2]  = 19'h12345;
        m_e[5]  = 1'b1; m_g[5]  = 1'b0; m_asid[5]  = 10'h021; m_vppn[5]  = 19'h0abcd;
        m_e[7]  = 1'b1; m_g[7]  = 1'b1; m_asid[7]  = 10'h009; m_vppn[7]  = 19'h12345;
        m_e[10] = 1'b1; m_g[10] = 1'b1; m_asid[10] = 10'h000; m_vppn[10] = 19'h55555;
    endtask

    function automatic logic [9:0] pick_asid();
        case ($urandom_range(3))
            0: return 10'h003;
            1: return 10'h009;
            2: return 10'h021;
            default: return 10'($urandom);
        endcase
    endfunction

    function automatic logic [18:0] pick_va();
        case ($urandom_range(2))
            0: return 19'h12345;
            1: return 19'h0abcd;
            default: return 19'($urandom);
        endcase
    endfunction

    initial begin
        summ_t  s;
        op_in_t o;
        bit     hit;
        string  nm;

        preset_tlb();
        // Reset with a would-be start on the WB inputs: everything must stay low.
        rst = 1'b1;
        drive_op(mk(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 10'h3, 19'h1, 32'h100, 4'd1, 10'h5, 19'h5));
        #12;
        chk_all_zero("reset-outputs");
        @(posedge clk); #1;
        drive_idle(4'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: {inputs, alignment of fill counter, expected summary}.
        //     v ex er sr rd wr fi iv op  asid    va        pc             idx  ca       cv
        add(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 10'h0,  19'h0,     32'h1c000100, 0,  10'h21,  19'h0abcd), -1,  2, 1,  2, 4'd5,  32'h1c000104);
        add(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 10'h0,  19'h0,     32'h1c000200, 3,  10'h0,   19'h0),      9,  2, 1,  2, 4'd9,  32'h1c000204);
        add(mk(1, 0, 0, 0, 0, 0, 0, 1, 5, 10'h3,  19'h12345, 32'h1c000300, 0,  10'h0,   19'h0),     -1, 17, 1, 17, 4'd2,  32'h1c000304);
        add(mk(1, 0, 0, 0, 0, 0, 0, 1, 7, 10'h3,  19'h12345, 32'h1c000400, 0,  10'h0,   19'h0),     -1,  1, 0,  1, 4'd0,  32'h1c000404);
        add(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 10'h0,  19'h0,     32'h1c000500, 4,  10'h0,   19'h0),     -1,  0, 0, -1, 4'd0,  32'h0);
        add(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 10'h0,  19'h0,     32'h1c000600, 11, 10'h0,   19'h0),     -1,  2, 1,  2, 4'd11, 32'h1c000604);
        add(mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 10'h0,  19'h0,     32'h1c000700, 0,  10'h0,   19'h0),     -1, 17, 2, 17, 4'd7,  32'h1c000704);
        add(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 10'h0,  19'h0,     32'h1c000800, 0,  10'h0,   19'h0),     -1, 17, 4, 17, 4'd2,  32'h1c000804);
        add(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 10'h0,  19'h0,     32'h1c000900, 6,  10'h21,  19'h0abcd), -1,  2, 1,  2, 4'd6,  32'h1c000904);
        add(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 10'h0,  19'h0,     32'h1c000a00, 0,  10'h21,  19'h0abcd), -1,  0, 0, -1, 4'd0,  32'h0);
        add(mk(1, 0, 0, 0, 0, 0, 0, 1, 6, 10'h21, 19'h0abcd, 32'h1c000b00, 0,  10'h0,   19'h0),     -1, 17, 1, 17, 4'd5,  32'h1c000b04);
        add(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 10'h0,  19'h0,     32'hfffffffc, 1,  10'h0,   19'h0),     -1,  2, 1,  2, 4'd1,  32'h00000000);
        add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 10'h0,  19'h0,     32'h1c000d00, 0,  10'h0,   19'h0),     -1,  0, 0, -1, 4'd0,  32'h0);
        add(mk(1, 0, 0, 0, 0, 0, 0, 1, 3, 10'h0,  19'h0,     32'h1c000e00, 0,  10'h0,   19'h0),     -1, 17, 2, 17, 4'd2,  32'h1c000e04);
        add(mk(1, 0, 0, 0, 0, 0, 1, 1, 4, 10'h21, 19'h0,     32'h1c000f00, 0,  10'h0,   19'h0),     -1, 17, 1, 17, 4'd5,  32'h1c000f04);
        add(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 10'h0,  19'h0,     32'h1c001000, 0,  10'h0,   19'h0),     -1, 17, 4, 17, 4'd2,  32'h1c001004);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].align >= 0) begin
                for (int w = 0; w < TLBNUM && (edges % TLBNUM) != tbl[i].align; w++) begin
                    drive_idle(4'd0);
                    @(posedge clk); #1;
                end
            end
            nm = $sformatf("vec%0d", i);
            run_op(tbl[i].in, nm, s);
            chk_int({nm, "-stall-cycles"}, s.stall_n, tbl[i].x_stall);
            chk_int({nm, "-strobe-cycles"}, s.strobe_n, tbl[i].x_strobes);
            chk_int({nm, "-refetch-cycle"}, s.rf_at, tbl[i].x_rf_at);
            if (tbl[i].x_strobes > 0) chk_int({nm, "-strobe-index"}, int'(s.first_idx), int'(tbl[i].x_idx));
            if (tbl[i].x_rf_at >= 0) chk_int({nm, "-refetch-pc"}, int'(s.rf_pc), int'(tbl[i].x_rf_pc));
        end

        // Reset in the middle of an invalidate walk, then a fresh walk from index 0.
        for (int i = 0; i < TLBNUM; i++) m_e[i] = 1'b1;
        o = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 10'h0, 19'h0, 32'h1c002000, 0, 10'h0, 19'h0);
        drive_op(o);
        @(posedge clk); #1;
        hit = 1'b0;
        for (int k = 0; k < 25 && !hit; k++) begin
            @(negedge clk);
            if (tlb_inv_we && tlb_inv_index == 4'd6) hit = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk_int("walk-reaches-index6", int'(hit), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("async-reset-mid-walk");
        @(negedge clk);
        chk_all_zero("held-reset");
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle(4'd0);
        run_op(o, "post-reset-walk", s);
        chk_int("post-reset-first-index", int'(s.first_idx), 0);
        chk_int("post-reset-strobe-cycles", s.strobe_n, TLBNUM);

        // Random back-to-back ops against random TLB contents.
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < TLBNUM; i++) begin
                m_e[i] = ($urandom_range(3) != 0); m_g[i] = 1'($urandom);
                m_asid[i] = pick_asid(); m_vppn[i] = pick_va();
            end
            o = mk(($urandom_range(9) != 0), ($urandom_range(9) == 0), ($urandom_range(9) == 0),
                   0, 0, 0, 0, 0,
                   ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(6)),
                   pick_asid(), pick_va(), $urandom, 4'($urandom), pick_asid(), pick_va());
            case ($urandom_range(4))
                0: o.srch = 1'b1;
                1: o.rd   = 1'b1;
                2: o.wr   = 1'b1;
                3: o.fill = 1'b1;
                default: o.inv = 1'b1;
            endcase
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(4))
                    0: o.srch = 1'b1;
                    1: o.rd   = 1'b1;
                    2: o.wr   = 1'b1;
                    3: o.fill = 1'b1;
                    default: o.inv = 1'b1;
                endcase
            end
            run_op(o, $sformatf("rand%0d", n), s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
